// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position generator: steps the sprite's top-left offset on divided
// frame ticks and reverses direction when the sprite reaches an active-area edge.
module sprite_motion_ctrl #(
  parameter int ACT_W  = 640,
  parameter int ACT_H  = 480,
  parameter int SPR_W  = 256,
  parameter int SPR_H  = 256,
  parameter int INIT_X = 100,
  parameter int INIT_Y = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_frame_tick,
  input  logic        i_enable,
  input  logic [2:0]  i_speed,
  input  logic [3:0]  i_frame_div,
  output logic [10:0] o_col,
  output logic [10:0] o_row,
  output logic        o_dir_x,
  output logic        o_dir_y,
  output logic        o_bounce,
  output logic [7:0]  o_bounce_cnt
);

  localparam logic [11:0] MAX_X = 12'(ACT_W - SPR_W);
  localparam logic [11:0] MAX_Y = 12'(ACT_H - SPR_H);

  logic [3:0]  r_divCnt;
  logic [11:0] w_spdExt;
  logic [11:0] w_nx;
  logic [11:0] w_ny;
  logic [10:0] w_nextCol;
  logic [10:0] w_nextRow;
  logic        w_nextDirX;
  logic        w_nextDirY;
  logic        w_hitX;
  logic        w_hitY;

  // Candidate next position for one step; widened to 12 bits so the sum cannot wrap
  always_comb begin
    w_spdExt   = {9'd0, i_speed};
    w_nx       = {1'b0, o_col} + w_spdExt;
    w_ny       = {1'b0, o_row} + w_spdExt;
    w_nextCol  = o_col;
    w_nextRow  = o_row;
    w_nextDirX = o_dir_x;
    w_nextDirY = o_dir_y;
    w_hitX     = 1'b0;
    w_hitY     = 1'b0;
    if (!o_dir_x) begin
      if (w_nx >= MAX_X) begin
        w_nextCol  = MAX_X[10:0];
        w_nextDirX = 1'b1;
        w_hitX     = 1'b1;
      end else begin
        w_nextCol = w_nx[10:0];
      end
    end else begin
      if ({1'b0, o_col} <= w_spdExt) begin
        w_nextCol  = 11'd0;
        w_nextDirX = 1'b0;
        w_hitX     = 1'b1;
      end else begin
        w_nextCol = o_col - 11'(i_speed);
      end
    end
    if (!o_dir_y) begin
      if (w_ny >= MAX_Y) begin
        w_nextRow  = MAX_Y[10:0];
        w_nextDirY = 1'b1;
        w_hitY     = 1'b1;
      end else begin
        w_nextRow = w_ny[10:0];
      end
    end else begin
      if ({1'b0, o_row} <= w_spdExt) begin
        w_nextRow  = 11'd0;
        w_nextDirY = 1'b0;
        w_hitY     = 1'b1;
      end else begin
        w_nextRow = o_row - 11'(i_speed);
      end
    end
  end

  // ">=" on the divider lets a lowered frame_div take effect without waiting for a wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_divCnt     <= 4'd0;
      o_col        <= 11'(INIT_X);
      o_row        <= 11'(INIT_Y);
      o_dir_x      <= 1'b0;
      o_dir_y      <= 1'b0;
      o_bounce     <= 1'b0;
      o_bounce_cnt <= 8'd0;
    end else begin
      o_bounce <= 1'b0;
      if (i_frame_tick && i_enable) begin
        if (r_divCnt >= i_frame_div) begin
          r_divCnt <= 4'd0;
          if (i_speed != 3'd0) begin
            o_col   <= w_nextCol;
            o_row   <= w_nextRow;
            o_dir_x <= w_nextDirX;
            o_dir_y <= w_nextDirY;
            if (w_hitX || w_hitY) begin
              o_bounce <= 1'b1;
              if (o_bounce_cnt != 8'hFF) o_bounce_cnt <= o_bounce_cnt + 8'd1;
            end
          end
        end else begin
          r_divCnt <= r_divCnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: table-driven segments checked against a
// scoreboard model every cycle, plus hand sequences for corner bounce, reset and saturation.
module tb_sprite_motion_ctrl;

  localparam int MAXX = 384;
  localparam int MAXY = 224;

  logic        clk;
  logic        reset;
  logic        frameTick;
  logic        enable;
  logic [2:0]  speed;
  logic [3:0]  frameDiv;
  logic [10:0] col, row;
  logic        dirX, dirY, bounce;
  logic [7:0]  bounceCnt;

  logic        cReset, cTick;
  logic [10:0] cCol, cRow;
  logic        cDirX, cDirY, cBounce;
  logic [7:0]  cBounceCnt;

  int total = 0;
  int bad = 0;

  sprite_motion_ctrl u_dut (
    .clk(clk), .reset(reset), .i_frame_tick(frameTick), .i_enable(enable),
    .i_speed(speed), .i_frame_div(frameDiv), .o_col(col), .o_row(row),
    .o_dir_x(dirX), .o_dir_y(dirY), .o_bounce(bounce), .o_bounce_cnt(bounceCnt)
  );

  sprite_motion_ctrl #(.INIT_X(380), .INIT_Y(220)) u_corner (
    .clk(clk), .reset(cReset), .i_frame_tick(cTick), .i_enable(enable),
    .i_speed(speed), .i_frame_div(frameDiv), .o_col(cCol), .o_row(cRow),
    .o_dir_x(cDirX), .o_dir_y(cDirY), .o_bounce(cBounce), .o_bounce_cnt(cBounceCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int col, row, dx, dy, bnc, cnt;
  } exp_t;

  typedef struct {
    bit rst; bit en; int spd; int div; int n; int gap;
    int eCol, eRow, eDx, eDy, eBnc, eCnt;
  } seg_t;

  exp_t sb[$];

  int mCol, mRow, mDx, mDy, mBnc, mCnt, mDiv;

  // Reference model of one clock edge, written directly from the behaviour description
  task automatic modelEdge(input bit rst, input bit tick, input bit en, input int spd, input int div);
    bit hx, hy;
    hx = 0; hy = 0;
    if (rst) begin
      mCol = 100; mRow = 100; mDx = 0; mDy = 0; mBnc = 0; mCnt = 0; mDiv = 0;
      return;
    end
    mBnc = 0;
    if (!(tick && en)) return;
    if (mDiv < div) begin
      mDiv++;
      return;
    end
    mDiv = 0;
    if (spd == 0) return;
    if (mDx == 0) begin
      if (mCol + spd >= MAXX) begin mCol = MAXX; mDx = 1; hx = 1; end
      else mCol = mCol + spd;
    end else begin
      if (mCol <= spd) begin mCol = 0; mDx = 0; hx = 1; end
      else mCol = mCol - spd;
    end
    if (mDy == 0) begin
      if (mRow + spd >= MAXY) begin mRow = MAXY; mDy = 1; hy = 1; end
      else mRow = mRow + spd;
    end else begin
      if (mRow <= spd) begin mRow = 0; mDy = 0; hy = 1; end
      else mRow = mRow - spd;
    end
    if (hx || hy) begin
      mBnc = 1;
      if (mCnt < 255) mCnt++;
    end
  endtask

  task automatic checkVal(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("[TB] FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (int'(col) != e.col || int'(row) != e.row || int'(dirX) != e.dx || int'(dirY) != e.dy ||
        int'(bounce) != e.bnc || int'(bounceCnt) != e.cnt) begin
      bad++;
      $display("[TB] FAIL %s: got col=%0d row=%0d dx=%0d dy=%0d b=%0d cnt=%0d, expected col=%0d row=%0d dx=%0d dy=%0d b=%0d cnt=%0d",
               name, col, row, dirX, dirY, bounce, bounceCnt, e.col, e.row, e.dx, e.dy, e.bnc, e.cnt);
    end
  endtask

  // One clock of stimulus: drive inputs, record the model's prediction, sample after the edge
  task automatic applyStimulus(input bit rst, input bit tick, input bit en, input int spd, input int div,
                               input string name);
    exp_t e;
    reset = rst; frameTick = tick; enable = en;
    speed = 3'(spd); frameDiv = 4'(div);
    modelEdge(rst, tick, en, spd, div);
    e.col = mCol; e.row = mRow; e.dx = mDx; e.dy = mDy; e.bnc = mBnc; e.cnt = mCnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  seg_t segs[10];

  initial begin
    reset = 1'b1; frameTick = 1'b0; enable = 1'b0; speed = 3'd0; frameDiv = 4'd0;
    cReset = 1'b1; cTick = 1'b0;
    mCol = 0; mRow = 0; mDx = 0; mDy = 0; mBnc = 0; mCnt = 0; mDiv = 0;

    segs[0] = '{1, 0, 0, 0, 2, 0, 100, 100, 0, 0, 0, 0};
    segs[1] = '{0, 1, 3, 0, 10, 1, 130, 130, 0, 0, 0, 0};
    segs[2] = '{1, 0, 0, 0, 2, 0, 100, 100, 0, 0, 0, 0};
    segs[3] = '{0, 1, 7, 0, 17, 0, 219, 219, 0, 0, 0, 0};
    segs[4] = '{0, 1, 7, 0, 1, 0, 226, 224, 0, 1, 1, 1};
    segs[5] = '{0, 1, 7, 0, 1, 0, 233, 217, 0, 1, 0, 1};
    segs[6] = '{1, 0, 0, 0, 2, 0, 100, 100, 0, 0, 0, 0};
    segs[7] = '{0, 1, 1, 2, 6, 1, 102, 102, 0, 0, 0, 0};
    segs[8] = '{0, 0, 1, 2, 5, 1, 102, 102, 0, 0, 0, 0};
    segs[9] = '{0, 1, 1, 2, 3, 1, 103, 103, 0, 0, 0, 0};

    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < segs[s].n; k++) begin
        applyStimulus(segs[s].rst, !segs[s].rst, segs[s].en, segs[s].spd, segs[s].div, $sformatf("seg%0d", s));
        for (int g = 0; g < segs[s].gap; g++)
          applyStimulus(0, 0, segs[s].en, segs[s].spd, segs[s].div, $sformatf("seg%0d_idle", s));
      end
      checkVal($sformatf("seg%0d_col", s), int'(col), segs[s].eCol);
      checkVal($sformatf("seg%0d_row", s), int'(row), segs[s].eRow);
      checkVal($sformatf("seg%0d_dirx", s), int'(dirX), segs[s].eDx);
      checkVal($sformatf("seg%0d_diry", s), int'(dirY), segs[s].eDy);
      checkVal($sformatf("seg%0d_bounce", s), int'(bounce), segs[s].eBnc);
      checkVal($sformatf("seg%0d_cnt", s), int'(bounceCnt), segs[s].eCnt);
    end

    // Reset arriving on the same edge as a bouncing tick must win
    applyStimulus(1, 0, 0, 0, 0, "rst_pre");
    for (int k = 0; k < 17; k++) applyStimulus(0, 1, 1, 7, 0, "rst_run");
    applyStimulus(1, 1, 1, 7, 0, "rst_vs_bounce");
    checkVal("rst_vs_bounce_col", int'(col), 100);
    checkVal("rst_vs_bounce_row", int'(row), 100);
    checkVal("rst_vs_bounce_b", int'(bounce), 0);
    checkVal("rst_vs_bounce_cnt", int'(bounceCnt), 0);

    // Saturation: keep ticking until at least 300 bounces have happened
    begin
      int bounces = 0;
      int cycles = 0;
      while (bounces < 300 && cycles < 20000) begin
        applyStimulus(0, 1, 1, 7, 0, "sat_run");
        if (mBnc) bounces++;
        cycles++;
      end
      checkVal("sat_bounce_budget", bounces, 300);
      checkVal("sat_cnt", int'(bounceCnt), 255);
    end

    // Corner instance: both axes hit on one step, counted once
    reset = 1'b0; frameTick = 1'b0; speed = 3'd4; frameDiv = 4'd0; enable = 1'b1;
    cReset = 1'b1; cTick = 1'b0;
    @(posedge clk); #1;
    checkVal("corner_reset_col", int'(cCol), 380);
    checkVal("corner_reset_row", int'(cRow), 220);
    cReset = 1'b0; cTick = 1'b1;
    @(posedge clk); #1;
    checkVal("corner_hit_col", int'(cCol), 384);
    checkVal("corner_hit_row", int'(cRow), 224);
    checkVal("corner_hit_dirx", int'(cDirX), 1);
    checkVal("corner_hit_diry", int'(cDirY), 1);
    checkVal("corner_hit_bounce", int'(cBounce), 1);
    checkVal("corner_hit_cnt", int'(cBounceCnt), 1);
    @(posedge clk); #1;
    cTick = 1'b0;
    checkVal("corner_back_col", int'(cCol), 380);
    checkVal("corner_back_row", int'(cRow), 220);
    checkVal("corner_back_bounce", int'(cBounce), 0);
    checkVal("corner_back_cnt", int'(cBounceCnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
